// File: rtl/fp_image_loader_pkg.sv
// Shared definitions for the front-panel image loader: sequencer states,
// button-pulser phases and default timing.
package fp_image_loader_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_LPC_SETUP,
      ST_LPC_PULSE,
      ST_LPC_HOLD,
      ST_GAP,
      ST_DEP_SETUP,
      ST_DEP_PULSE,
      ST_DEP_HOLD,
      ST_START_SETUP,
      ST_START_PULSE,
      ST_START_HOLD,
      ST_RUN_ARM,
      ST_RUNNING,
      ST_HALTED
   } fp_loader_state_t;

   typedef enum logic [2:0] {
      PH_IDLE,
      PH_GAP,
      PH_SETUP,
      PH_PULSE,
      PH_HOLD
   } fp_phase_t;

   localparam logic [11:0] FP_DEFAULT_START_PC = 12'o0200;
   localparam int FP_DEFAULT_SETUP_CYC = 10;
   localparam int FP_DEFAULT_PULSE_CYC = 10;
   localparam int FP_DEFAULT_HOLD_CYC  = 10;
   localparam int FP_DEFAULT_GAP_CYC   = 30;

   function automatic int fp_max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/fp_image_loader_button_pulser.sv
// One front-panel button press: optional leading gap, then setup, pulse, hold.
// Holds the only phase timer of the loader.
module fp_button_pulser
   import fp_image_loader_pkg::*;
#(
   parameter int SETUP_CYC = FP_DEFAULT_SETUP_CYC,
   parameter int PULSE_CYC = FP_DEFAULT_PULSE_CYC,
   parameter int HOLD_CYC  = FP_DEFAULT_HOLD_CYC,
   parameter int GAP_CYC   = FP_DEFAULT_GAP_CYC
) (
   input  logic clk,
   input  logic rst,
   input  logic go,
   input  logic with_gap,
   input  logic sel_deposit,
   output logic phase_end,
   output logic done,
   output logic load_pc_btn,
   output logic deposit_btn
);

   localparam int TW = $clog2(fp_max4(SETUP_CYC, PULSE_CYC, HOLD_CYC, GAP_CYC) + 1);
   localparam logic [TW-1:0] SETUP_T = TW'(SETUP_CYC - 1);
   localparam logic [TW-1:0] PULSE_T = TW'(PULSE_CYC - 1);
   localparam logic [TW-1:0] HOLD_T  = TW'(HOLD_CYC - 1);
   localparam logic [TW-1:0] GAP_T   = TW'(GAP_CYC - 1);

   fp_phase_t     phase_reg, phase_next;
   logic [TW-1:0] timer_reg, timer_next;
   logic          sel_reg, sel_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_reg <= PH_IDLE;
         timer_reg <= '0;
         sel_reg   <= 1'b0;
      end else begin
         phase_reg <= phase_next;
         timer_reg <= timer_next;
         sel_reg   <= sel_next;
      end
   end

   // A new request wins over the phase in progress, so the caller can chain
   // presses in the cycle the previous hold completes.
   always_comb begin
      phase_next = phase_reg;
      timer_next = timer_reg;
      sel_next   = sel_reg;
      if (go) begin
         sel_next   = sel_deposit;
         phase_next = with_gap ? PH_GAP : PH_SETUP;
         timer_next = with_gap ? GAP_T : SETUP_T;
      end else if (phase_reg != PH_IDLE) begin
         if (timer_reg == '0) begin
            case (phase_reg)
               PH_GAP: begin
                  phase_next = PH_SETUP;
                  timer_next = SETUP_T;
               end
               PH_SETUP: begin
                  phase_next = PH_PULSE;
                  timer_next = PULSE_T;
               end
               PH_PULSE: begin
                  phase_next = PH_HOLD;
                  timer_next = HOLD_T;
               end
               default: begin
                  phase_next = PH_IDLE;
                  timer_next = '0;
               end
            endcase
         end else begin
            timer_next = timer_reg - 1'b1;
         end
      end
   end

   assign phase_end   = (phase_reg != PH_IDLE) && (timer_reg == '0);
   assign done        = (phase_reg == PH_HOLD) && (timer_reg == '0);
   assign load_pc_btn = (phase_reg == PH_PULSE) && !sel_reg;
   assign deposit_btn = (phase_reg == PH_PULSE) && sel_reg;

endmodule

// File: rtl/fp_image_loader.sv
// Front-panel image loader: turns an (addr, data, last) stream into Load-PC /
// Deposit button sequences, then starts the CPU and waits for it to halt.
// Build option FP_LOADER_ADDR_SKIP_EN skips Load-PC for sequential addresses.
module fp_image_loader
   import fp_image_loader_pkg::*;
#(
   parameter int W                = 12,
   parameter int SETUP_CYC        = FP_DEFAULT_SETUP_CYC,
   parameter int PULSE_CYC        = FP_DEFAULT_PULSE_CYC,
   parameter int HOLD_CYC         = FP_DEFAULT_HOLD_CYC,
   parameter int GAP_CYC          = FP_DEFAULT_GAP_CYC,
   parameter logic [W-1:0] START_PC = W'(FP_DEFAULT_START_PC)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_addr,
   input  logic [W-1:0] in_data,
   input  logic         in_last,
   input  logic         run_led,
   output logic [W-1:0] sw_out,
   output logic         sw_run,
   output logic         load_pc_btn,
   output logic         deposit_btn,
   output logic         busy,
   output logic         done,
   output logic [W:0]   words_loaded
);

   fp_loader_state_t state_reg, state_next;
   logic [W-1:0]     sw_out_reg, sw_out_next;
   logic [W-1:0]     data_reg, data_next;
   logic             last_reg, last_next;
   logic             sw_run_reg, sw_run_next;
   logic [W:0]       words_reg, words_next;

   logic go, with_gap, sel_deposit, phase_end, press_done, skip, accept;

   fp_button_pulser #(
      .SETUP_CYC (SETUP_CYC),
      .PULSE_CYC (PULSE_CYC),
      .HOLD_CYC  (HOLD_CYC),
      .GAP_CYC   (GAP_CYC)
   ) u_pulser (
      .clk         (clk),
      .rst         (rst),
      .go          (go),
      .with_gap    (with_gap),
      .sel_deposit (sel_deposit),
      .phase_end   (phase_end),
      .done        (press_done),
      .load_pc_btn (load_pc_btn),
      .deposit_btn (deposit_btn)
   );

   assign accept = in_valid && in_ready;

`ifdef FP_LOADER_ADDR_SKIP_EN
   logic [W-1:0] addr_reg, addr_next;
   logic [W-1:0] next_addr_reg, next_addr_next;
   logic         have_prev_reg, have_prev_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_reg      <= '0;
         next_addr_reg <= '0;
         have_prev_reg <= 1'b0;
      end else begin
         addr_reg      <= addr_next;
         next_addr_reg <= next_addr_next;
         have_prev_reg <= have_prev_next;
      end
   end

   // Deposit auto-increments the CPU PC, so a word at the expected address
   // needs no explicit Load-PC.
   always_comb begin
      addr_next      = addr_reg;
      next_addr_next = next_addr_reg;
      have_prev_next = have_prev_reg;
      if (accept) addr_next = in_addr;
      if (state_reg == ST_DEP_HOLD && press_done) begin
         next_addr_next = addr_reg + 1'b1;
         have_prev_next = 1'b1;
      end
   end

   assign skip = have_prev_reg && (in_addr == next_addr_reg);
`else
   assign skip = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= ST_IDLE;
         sw_out_reg <= '0;
         data_reg   <= '0;
         last_reg   <= 1'b0;
         sw_run_reg <= 1'b0;
         words_reg  <= '0;
      end else begin
         state_reg  <= state_next;
         sw_out_reg <= sw_out_next;
         data_reg   <= data_next;
         last_reg   <= last_next;
         sw_run_reg <= sw_run_next;
         words_reg  <= words_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      sw_out_next = sw_out_reg;
      data_next   = data_reg;
      last_next   = last_reg;
      sw_run_next = sw_run_reg;
      words_next  = words_reg;
      go          = 1'b0;
      with_gap    = 1'b0;
      sel_deposit = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (accept) begin
               data_next = in_data;
               last_next = in_last;
               go        = 1'b1;
               if (skip) begin
                  state_next  = ST_DEP_SETUP;
                  sel_deposit = 1'b1;
                  sw_out_next = in_data;
               end else begin
                  state_next  = ST_LPC_SETUP;
                  sw_out_next = in_addr;
               end
            end
         end
         ST_LPC_SETUP:   if (phase_end) state_next = ST_LPC_PULSE;
         ST_LPC_PULSE:   if (phase_end) state_next = ST_LPC_HOLD;
         ST_LPC_HOLD: begin
            if (press_done) begin
               state_next  = ST_GAP;
               go          = 1'b1;
               with_gap    = 1'b1;
               sel_deposit = 1'b1;
            end
         end
         ST_GAP: begin
            if (phase_end) begin
               state_next  = ST_DEP_SETUP;
               sw_out_next = data_reg;
            end
         end
         ST_DEP_SETUP:   if (phase_end) state_next = ST_DEP_PULSE;
         ST_DEP_PULSE:   if (phase_end) state_next = ST_DEP_HOLD;
         ST_DEP_HOLD: begin
            if (press_done) begin
               if (words_reg != '1) words_next = words_reg + 1'b1;
               if (last_reg) begin
                  state_next  = ST_START_SETUP;
                  sw_out_next = START_PC;
                  go          = 1'b1;
               end else begin
                  state_next = ST_IDLE;
               end
            end
         end
         ST_START_SETUP: if (phase_end) state_next = ST_START_PULSE;
         ST_START_PULSE: if (phase_end) state_next = ST_START_HOLD;
         ST_START_HOLD: begin
            if (press_done) begin
               state_next  = ST_RUN_ARM;
               sw_run_next = 1'b1;
            end
         end
         ST_RUN_ARM:     if (run_led)  state_next = ST_RUNNING;
         ST_RUNNING:     if (!run_led) state_next = ST_HALTED;
         ST_HALTED:      state_next = ST_HALTED;
         default:        state_next = ST_IDLE;
      endcase
   end

   // Gated by rst so every output reads 0 while reset is held.
   assign in_ready     = (state_reg == ST_IDLE) && !rst;
   assign busy         = (state_reg != ST_IDLE) && (state_reg != ST_HALTED);
   assign done         = (state_reg == ST_HALTED);
   assign sw_out       = sw_out_reg;
   assign sw_run       = sw_run_reg;
   assign words_loaded = words_reg;

endmodule
